// File: rtl/mem_subword_unit_pkg.sv
// Shared definitions for the sub-word load/store engine: access sizes, FSM states
// and the lane helpers used by the top-level store merge.
package mem_subword_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace the addressed little-endian lane of word with the low bits of wdata.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_B: begin
        case (off)
          2'b00:   res[7:0]   = wdata[7:0];
          2'b01:   res[15:8]  = wdata[7:0];
          2'b10:   res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_subword_unit_ldext.sv
// Load lane extractor: selects the byte/halfword lane of a memory word and
// sign- or zero-extends it to 32 bits; words pass through unchanged.
module ldext
  import mem_subword_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = 32'h0000_0000;
    case (size)
      SZ_B: begin
        case (addr)
          2'b00:   byte_s = word[7:0];
          2'b01:   byte_s = word[15:8];
          2'b10:   byte_s = word[23:16];
          default: byte_s = word[31:24];
        endcase
        result = {{24{byte_s[7] & ~uns}}, byte_s};
      end
      SZ_H: begin
        if (addr[1]) half_s = word[31:16];
        else         half_s = word[15:0];
        result = {{16{half_s[15] & ~uns}}, half_s};
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_subword_unit.sv
// Sub-word load/store engine between the datapath and a word-only data memory.
// Byte/half stores are done as a read-modify-write of the containing word.
module mem_subword_unit
  import mem_subword_unit_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t        state_r, state_nxt_s;
  logic          we_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   ext_s;
  logic          accept_s;

  assign accept_s = req_valid && (state_r == ST_IDLE);

  ldext u_ldext (
    .word   (mem_rdata),
    .addr   (addr_r[1:0]),
    .size   (size_r),
    .uns    (uns_r),
    .result (ext_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= req_we;
      size_r  <= req_size;
      uns_r   <= req_unsigned;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end else begin
      we_r    <= we_r;
      size_r  <= size_r;
      uns_r   <= uns_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Next-state decode; full-word stores skip the read.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_valid)                                 state_nxt_s = ST_IDLE;
        else if (is_misaligned(req_size, req_addr[1:0])) state_nxt_s = ST_ERR;
        else if (req_we && (req_size == SZ_W))          state_nxt_s = ST_WRITE;
        else                                            state_nxt_s = ST_READ;
      end
      ST_READ:  state_nxt_s = we_r ? ST_MERGE : ST_RESP;
      ST_MERGE: state_nxt_s = ST_RESP;
      ST_WRITE: state_nxt_s = ST_RESP;
      ST_RESP:  state_nxt_s = ST_IDLE;
      ST_ERR:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from state and latched request only (mem_rdata feeds data, not control).
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0000_0000;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_READ: begin
        mem_en   = 1'b1;
        mem_addr = {addr_r[AW-1:2], 2'b00};
      end
      ST_MERGE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_r[AW-1:2], 2'b00};
        mem_wdata = merge_lane(mem_rdata, wdata_r, addr_r[1:0], size_r);
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_r[AW-1:2], 2'b00};
        mem_wdata = wdata_r;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_r ? 32'h0000_0000 : ext_s;
      end
      ST_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_subword_unit.sv
// Scoreboard bench for mem_subword_unit: directed requests push expected responses,
// a monitor pops them on rsp_valid and also checks latency and memory traffic.
module tb_mem_subword_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  mem_subword_unit #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory with a backdoor preload port.
  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h00;
  logic [31:0] bd_data = 32'h0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: counts memory strobes and pops the scoreboard on every response.
  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_en) begin
        if (mem_we) wr_cnt++;
        else        rd_cnt++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.nm, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
          chk({e.nm, "_lat"}, cyc - e.acc, e.lat);
          chk({e.nm, "_reads"}, rd_cnt, e.nrd);
          chk({e.nm, "_writes"}, wr_cnt, e.nwr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input int nrd, input int nwr, input string nm,
                       input bit push, input bit hold, output int acc);
    int w;
    exp_t e;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got req_ready=0 expected 1 within 20 cycles", nm);
    end
    acc = cyc;
    if (push) begin
      e.nm = nm; e.rdata = exp_rd; e.err = exp_err; e.acc = acc;
      e.lat = lat; e.nrd = nrd; e.nwr = nwr;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_ctl"}, {28'd0, rsp_valid, rsp_err, mem_en, mem_we}, 32'd0);
    chk({nm, "_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_maddr"}, mem_addr, 32'd0);
    chk({nm, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  int a0, a1;
  logic [31:0] saved;

  initial begin
    // Reset and preload mem[0x100].
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 8'h40; bd_data = 32'h8081_7F02;
    @(negedge clk);
    bd_we = 1'b0;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Loads: lane 1 of 0x80817F02 is 0x7F, lane 2 is 0x81, lane 3 is 0x80.
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000_007F, 1'b0, 2, 1, 0, "lb_101", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000_007F, 1'b0, 2, 1, 0, "lbu_101", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0000_0002, 1'b0, 2, 1, 0, "lb_100", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'hFFFF_FF81, 1'b0, 2, 1, 0, "lb_102", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h0000_0081, 1'b0, 2, 1, 0, "lbu_102", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0, "lbu_103", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_8081, 1'b0, 2, 1, 0, "lh_102", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_8081, 1'b0, 2, 1, 0, "lhu_102", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000_7F02, 1'b0, 2, 1, 0, "lh_100", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8081_7F02, 1'b0, 2, 1, 0, "lw_100", 1'b1, 1'b0, a0);
    drain();

    // Sub-word stores: read-modify-write, response three cycles after accept.
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h1234_56AA, 32'h0, 1'b0, 3, 1, 1, "sb_103", 1'b1, 1'b0, a0);
    drain();
    chk("mem_after_sb", mem[8'h40], 32'hAA81_7F02);
    issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 1, "sh_100", 1'b1, 1'b0, a0);
    drain();
    chk("mem_after_sh", mem[8'h40], 32'hAA81_BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 1, 0, "lb_103", 1'b1, 1'b0, a0);

    // Misaligned and illegal requests never touch memory.
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 0, "lh_101_err", 1'b1, 1'b0, a0);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0, 0, "sw_102_err", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0, "sz11_err", 1'b1, 1'b0, a0);
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 0, "lw_101_err", 1'b1, 1'b0, a0);
    drain();
    chk("mem_after_err", mem[8'h40], 32'hAA81_BEEF);

    // Back-to-back with req_valid held high.
    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h1234_5678, 32'h0, 1'b0, 2, 0, 1, "sw_104", 1'b1, 1'b1, a0);
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 0, "lw_104", 1'b1, 1'b0, a1);
    chk("b2b_accept_gap", a1 - a0, 32'd3);
    drain();

    // Reset in the READ cycle of a byte store aborts it without a write.
    saved = mem[8'h40];
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0055, 32'h0, 1'b0, 3, 1, 1, "sb_abort", 1'b0, 1'b0, a0);
    chk("abort_in_read", {31'd0, mem_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mem_after_abort", mem[8'h40], saved);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hAA81_BEEF, 1'b0, 2, 1, 0, "lw_after_rst", 1'b1, 1'b0, a0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
